// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: turns load-use, branch-redirect and data-memory
// wait conditions into per-stage stop/flush controls, with a post-reset fetch blackout.
module hazard_ctrl #(
  parameter int STARTUP_CYCLES = 2,
  parameter int MEM_TIMEOUT    = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stop,
  output logic             if_id_stop,
  output logic             if_id_flush,
  output logic             id_ex_stop,
  output logic             id_ex_flush,
  output logic             ex_mem_stop,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       dbg_state
);

  localparam int BOOT_W = ($clog2(STARTUP_CYCLES + 1) > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BOOT_W-1:0] BOOT_INIT = BOOT_W'(STARTUP_CYCLES);
  localparam logic [BOOT_W-1:0] BOOT_ONE  = BOOT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam state_t ST_INIT = (STARTUP_CYCLES == 0) ? ST_RUN : ST_BOOT;

  state_t            r_state, w_state_nxt;
  logic [BOOT_W-1:0] r_boot_cnt, w_boot_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
  logic              r_mem_timeout, w_timeout_nxt;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
  logic              w_stall_evt, w_flush_evt;
  logic              w_mem_stall, w_load_use;

  assign w_mem_stall = mem_req & ~mem_ready;
  assign w_load_use  = ex_is_load & (ex_rd != 5'd0) &
                       ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                        (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_INIT;
      r_boot_cnt    <= BOOT_INIT;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_boot_cnt    <= w_boot_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_mem_timeout <= w_timeout_nxt;
      if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  always_comb begin
    pc_stop       = 1'b0;
    if_id_stop    = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stop    = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stop   = 1'b0;
    mem_wb_flush  = 1'b0;
    w_state_nxt   = r_state;
    w_boot_nxt    = r_boot_cnt;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_nxt = r_mem_timeout;
    w_stall_evt   = 1'b0;
    w_flush_evt   = 1'b0;

    case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        if (w_mem_stall) begin
          // EX and ID hold their contents, so branch/load-use are seen again once memory completes.
          pc_stop      = 1'b1;
          if_id_stop   = 1'b1;
          id_ex_stop   = 1'b1;
          ex_mem_stop  = 1'b1;
          mem_wb_flush = 1'b1;
          w_stall_evt  = 1'b1;
          w_state_nxt  = ST_MEM_WAIT;
          if (r_state == ST_RUN)
            w_wait_nxt = WAIT_ONE;
          else if (r_wait_cnt != WAIT_MAX)
            w_wait_nxt = r_wait_cnt + WAIT_ONE;
          if (w_wait_nxt == WAIT_MAX) w_timeout_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = '0;
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            w_flush_evt = 1'b1;
          end else if (w_load_use) begin
            pc_stop     = 1'b1;
            if_id_stop  = 1'b1;
            id_ex_flush = 1'b1;
            w_stall_evt = 1'b1;
          end
        end
      end
      default: begin
        pc_stop     = 1'b1;
        if_id_flush = 1'b1;
        w_boot_nxt  = r_boot_cnt - BOOT_ONE;
        if (r_boot_cnt <= BOOT_ONE) w_state_nxt = ST_RUN;
      end
    endcase

    // Reset overrides the decoded controls so fetch is held even when no boot phase is configured.
    if (rst) begin
      pc_stop      = 1'b1;
      if_id_stop   = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_stop   = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_stop  = 1'b0;
      mem_wb_flush = 1'b0;
    end
  end

  assign mem_timeout = r_mem_timeout;
  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed stimulus for hazard_ctrl, checked cycle by cycle
// against a behavioural model of the stall/flush rules.
module tb_hazard_ctrl;

  localparam int SU = 2;
  localparam int TO = 4;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_is_load, ex_branch_taken;
  logic          mem_req, mem_ready;
  logic          pc_stop, if_id_stop, if_id_flush, id_ex_stop, id_ex_flush;
  logic          ex_mem_stop, mem_wb_flush, mem_timeout;
  logic [CW-1:0] stall_count, flush_count;
  logic [1:0]    dbg_state;

  hazard_ctrl #(.STARTUP_CYCLES(SU), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stop(pc_stop), .if_id_stop(if_id_stop), .if_id_flush(if_id_flush),
    .id_ex_stop(id_ex_stop), .id_ex_flush(id_ex_flush), .ex_mem_stop(ex_mem_stop),
    .mem_wb_flush(mem_wb_flush), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: remaining boot cycles, consecutive wait cycles, sticky flag, counters.
  int m_boot, m_wait, m_stall, m_flush;
  bit m_to;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_outs();
    return {pc_stop, if_id_stop, if_id_flush, id_ex_stop, id_ex_flush, ex_mem_stop, mem_wb_flush};
  endfunction

  task automatic model_reset();
    m_boot = SU; m_wait = 0; m_stall = 0; m_flush = 0; m_to = 0;
  endtask

  // Expected outputs as {pc, ifs, iff, ids, idf, exs, mwf}; also updates model for the coming edge.
  task automatic model_cycle(output logic [6:0] exp_o);
    bit mstall, lu;
    mstall = mem_req && !mem_ready;
    lu = ex_is_load && ex_rd != 0 &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    exp_o = '0;
    if (m_boot > 0) begin
      exp_o = 7'b1010000;
      m_boot--;
    end else if (mstall) begin
      exp_o = 7'b1101011;
      m_wait = (m_wait + 1 > TO) ? TO : m_wait + 1;
      if (m_wait >= TO) m_to = 1;
      m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    end else begin
      m_wait = 0;
      if (ex_branch_taken) begin
        exp_o = 7'b0010100;
        m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      end else if (lu) begin
        exp_o = 7'b1100100;
        m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end
    end
  endtask

  function automatic int exp_state();
    return (m_boot > 0) ? 0 : ((m_wait > 0) ? 2 : 1);
  endfunction

  task automatic check_regs();
    check_eq("mem_timeout", 32'(mem_timeout), 32'(m_to));
    check_eq("stall_count", 32'(stall_count), 32'(m_stall));
    check_eq("flush_count", 32'(flush_count), 32'(m_flush));
    check_eq("state", 32'(dbg_state), 32'(exp_state()));
  endtask

  // Called just after a negedge: check this cycle's outputs, then advance to the next negedge.
  task automatic step();
    logic [6:0] exp_o;
    #1;
    check_regs();
    model_cycle(exp_o);
    check_eq("ctrl_outs", 32'(dut_outs()), 32'(exp_o));
    @(negedge clk);
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2,
                        input logic [4:0] rd, input bit ld, input bit br, input bit req, input bit rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_is_load = ld; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
  endtask

  task automatic set_rand();
    set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
  endtask

  // Entered at a negedge; raises rst mid-cycle so the asynchronous effect is visible before any edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_outs", 32'(dut_outs()), 32'h50);
    check_regs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    model_reset();
    @(negedge clk);
    do_reset();

    // Boot blackout with a live load-use hazard on the inputs.
    set_in(5'd0, 5'd5, 1, 1, 5'd5, 1, 0, 0, 1);
    step(); step();
    check_eq("boot_no_stall", 32'(stall_count), 32'd0);
    // First RUN cycle: the same hazard now bubbles once.
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    check_eq("lu_stall_cnt", 32'(stall_count), 32'd1);
    set_in(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 1);
    step();
    // Branch wins over a simultaneous load-use.
    set_in(5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 0, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    check_eq("br_flush_cnt", 32'(flush_count), 32'd1);
    check_eq("br_stall_cnt", 32'(stall_count), 32'd1);

    // Three wait cycles with a pending branch, then ready.
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
    repeat (3) step();
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    check_eq("mw_stall_cnt", 32'(stall_count), 32'd4);
    check_eq("mw_flush_cnt", 32'(flush_count), 32'd2);
    check_eq("mw_to_clear", 32'(mem_timeout), 32'd0);

    // Timeout: six consecutive waits, flag stays after ready.
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (6) step();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (3) step();
    check_eq("to_sticky", 32'(mem_timeout), 32'd1);

    // Reset in the middle of a memory wait.
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) step();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) step();

    // Drive stall_count into saturation with back-to-back load-use hazards.
    set_in(5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 0, 1);
    repeat (CMAX + 6) step();
    check_eq("stall_sat", 32'(stall_count), 32'(CMAX));

    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        set_rand();
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
